// File: rtl/frogger_round_ctrl.sv
// Round/phase sequencer for Frogger: start countdown, death pause, level advance,
// game-over and game-win screens. Drives respawn/freeze to the moving objects.
module frogger_round_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int MAX_LEVEL     = 4,
  parameter int TICKS_PER_SEC = 60,
  parameter int COUNT_SECS    = 3,
  parameter int DEATH_FRAMES  = 30
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       frame_tick,
  input  logic       start_i,
  input  logic       collision_i,
  input  logic       frog_goal_i,
  output logic       respawn_o,
  output logic       freeze_o,
  output logic [1:0] lives_o,
  output logic [2:0] level_o,
  output logic [1:0] countdown_o,
  output logic       gameover_o,
  output logic       gamewin_o,
  output logic [2:0] state_o
);

  localparam int CNT_MAX = (TICKS_PER_SEC > DEATH_FRAMES) ? TICKS_PER_SEC : DEATH_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] TPS_LAST   = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [1:0]       CD_LOAD    = 2'(COUNT_SECS);
  localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [2:0]       MAX_LVL    = 3'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_DYING     = 3'd3,
    S_LEVELUP   = 3'd4,
    S_OVER      = 3'd5,
    S_WIN       = 3'd6
  } state_t;

  state_t           r_state;
  logic             r_start_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_respawn;
  logic             r_freeze;
  logic [1:0]       r_lives;
  logic [2:0]       r_level;
  logic [1:0]       r_countdown;
  logic             r_gameover;
  logic             r_gamewin;

  logic w_start_edge;

  // A life lost with none left stays at zero; the DYING exit then routes to OVER.
  function automatic logic [1:0] lives_dec(input logic [1:0] lives);
    return (lives == 2'd0) ? 2'd0 : lives - 2'd1;
  endfunction

  assign w_start_edge = start_i & ~r_start_d;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_cnt       <= '0;
      r_respawn   <= 1'b0;
      r_freeze    <= 1'b1;
      r_lives     <= LIVES_LOAD;
      r_level     <= 3'd1;
      r_countdown <= 2'd0;
      r_gameover  <= 1'b0;
      r_gamewin   <= 1'b0;
    end else begin
      r_start_d <= start_i;
      r_respawn <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state     <= S_COUNTDOWN;
            r_respawn   <= 1'b1;
            r_countdown <= CD_LOAD;
            r_cnt       <= '0;
          end
        end

        S_COUNTDOWN: begin
          if (frame_tick) begin
            if (r_cnt == TPS_LAST) begin
              r_cnt       <= '0;
              r_countdown <= r_countdown - 2'd1;
              if (r_countdown == 2'd1) begin
                r_state  <= S_PLAY;
                r_freeze <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_PLAY: begin
          // Collision takes priority over reaching the goal in the same cycle.
          if (collision_i) begin
            r_state  <= S_DYING;
            r_freeze <= 1'b1;
            r_lives  <= lives_dec(r_lives);
            r_cnt    <= '0;
          end else if (frog_goal_i) begin
            r_state  <= S_LEVELUP;
            r_freeze <= 1'b1;
          end
        end

        S_DYING: begin
          if (frame_tick) begin
            if (r_cnt == DEATH_LAST) begin
              r_cnt <= '0;
              if (r_lives == 2'd0) begin
                r_state    <= S_OVER;
                r_gameover <= 1'b1;
              end else begin
                r_state     <= S_COUNTDOWN;
                r_respawn   <= 1'b1;
                r_countdown <= CD_LOAD;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_LEVELUP: begin
          r_cnt <= '0;
          if (r_level == MAX_LVL) begin
            r_state   <= S_WIN;
            r_gamewin <= 1'b1;
          end else begin
            r_state     <= S_COUNTDOWN;
            r_level     <= r_level + 3'd1;
            r_respawn   <= 1'b1;
            r_countdown <= CD_LOAD;
          end
        end

        S_OVER, S_WIN: begin
          if (w_start_edge) begin
            r_state     <= S_COUNTDOWN;
            r_lives     <= LIVES_LOAD;
            r_level     <= 3'd1;
            r_respawn   <= 1'b1;
            r_countdown <= CD_LOAD;
            r_cnt       <= '0;
            r_gameover  <= 1'b0;
            r_gamewin   <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_freeze <= 1'b1;
        end
      endcase
    end
  end

  assign respawn_o   = r_respawn;
  assign freeze_o    = r_freeze;
  assign lives_o     = r_lives;
  assign level_o     = r_level;
  assign countdown_o = r_countdown;
  assign gameover_o  = r_gameover;
  assign gamewin_o   = r_gamewin;
  assign state_o     = r_state;

endmodule
